cpu_state_decode: RTL
=====================

// Module: cpu_state_decode
// PURPOSE
//  Consumer of the control FSM's state/cycle outputs: turns each STATE_* code into registered
//  one-hot bus strobes for PC, MAR, RAM, IR, A/B registers, ALU and output port.
//  Resolves conditional jumps, handshakes OUT with the display, latches HALT, flags illegal states.
//  Sits between the control FSM and the datapath/bus inside the CPU top level.
// PARAMETERS
//  CNT_W   16  width of performance counters (only with CPU_DECODE_PERF_EN)
// PORTS
//  clk          in   1   clock, all outputs registered on posedge
//  reset_cycle  in   1   asynchronous, active-high reset
//  state        in   4   current STATE_* code from control FSM
//  opcode       in   8   current instruction byte from IR
//  zero_flag    in   1   ALU zero flag
//  reg_a        in   8   A register value for OUT
//  out_ready    in   1   display accepts out_data
//  pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load, a_load, b_load, alu_en  out 1 each  bus strobes
//  out_valid    out  1   out_data valid; held until out_ready
//  out_data     out  8   captured A value
//  stall        out  1   out_valid && !out_ready; control FSM must hold its cycle
//  halted       out  1   sticky halt
//  instr_done   out  1   one-clock pulse per retired instruction
//  illegal      out  1   sticky: undefined state code seen
//  retired_cnt, stall_cnt  out CNT_W  (only with CPU_DECODE_PERF_EN)
// BEHAVIOUR
//  - Reset: every output 0, out_data 0, counters 0. Reset mid-OUT drops out_valid at once.
//  - Latency: strobes for state S are visible exactly 1 clk after S is sampled; each strobe is high 1 clk.
//  - State codes (shared parameters include): FETCH_PC=0 FETCH_INST=1 HALT=2 JUMP=3 OUT_A=4 NEXT=5
//    LDI=6 LOAD_ADDR=7 RAM_B=8 ALU_OP=9 MOV_FETCH=10 MOV_LOAD=11 MOV_STORE=12; 13-15 illegal.
//  - Strobe map: FETCH_PC->mar_load; FETCH_INST->ram_rd+ir_load+pc_inc; LOAD_ADDR->ram_rd+mar_load+pc_inc;
//    LDI->ram_rd+a_load+pc_inc; RAM_B->ram_rd+b_load; ALU_OP->alu_en+a_load;
//    MOV_FETCH->ram_rd+mar_load+pc_inc; MOV_LOAD->ram_rd; MOV_STORE->ram_wr; NEXT->instr_done.
//  - JUMP: opcode==OP_JMP -> pc_load; OP_JEZ -> pc_load if zero_flag else pc_inc;
//    OP_JNZ -> pc_load if !zero_flag else pc_inc (operand skipped). zero_flag is sampled with state.
//  - OUT FSM: IDLE -> (state==OUT_A) -> VALID: out_data<=reg_a, out_valid=1.
//    VALID -> IDLE on a clk with out_ready=1.
//    While VALID, a repeat OUT_A is ignored (no recapture) and stall=1 until accepted.
//    out_ready already high on the first valid clk -> out_valid lasts exactly 1 clk.
//  - HALT: halted<=1, sticky until reset.
//    While halted, all strobes stay 0 and instr_done stays 0.
//    A pending OUT still completes its handshake.
//  - Illegal state: all strobes 0 for that clk; illegal<=1 (sticky); no other effect.
//  - stall asserted: strobes for the incoming (held) state are suppressed, so no double pc_inc.
// CONFIGURATION
//  CPU_DECODE_PERF_EN defined:
//    retired_cnt +1 per instr_done; stall_cnt +1 per stall clk.
//    Both wrap modulo 2^CNT_W, zero on reset.
//  Undefined: the counters and their ports are absent; CNT_W is unused.
// TESTING
//  1. reset_cycle pulse mid-run (async, between edges) -> all outputs 0 immediately, before next edge.
//  2. State sequence 0,1,7,8,9,5 (ADD) -> mar_load; ram_rd+ir_load+pc_inc; ram_rd+mar_load+pc_inc;
//     ram_rd+b_load; alu_en+a_load; instr_done, each 1 clk late.
//  3. JUMP with OP_JEZ: zero_flag=1 -> pc_load=1, pc_inc=0; zero_flag=0 -> pc_inc=1, pc_load=0; OP_JNZ inverse.
//  4. OUT_A with reg_a=0x5A, out_ready low 3 clks -> out_valid=1 and stall=1 for 3 clks,
//     out_data=0x5A; drops 1 clk after out_ready=1.
//  5. HALT then FETCH_PC -> halted=1 sticky, mar_load stays 0; reset clears halted.
//  6. state=14 -> illegal=1 and all strobes 0; with PERF_EN, 3 NEXT states -> retired_cnt=3.

Source files
------------

// File: rtl/cpu_state_decode_if.sv
// -----------------------------------------------------------------------------
// cpu_state_decode_if
//   Bus strobes and OUT-port handshake between the state decoder and the
//   datapath / display.
//   master : decoder side (drives strobes, out_valid, out_data, stall;
//            receives out_ready)
//   slave  : datapath / display side (the mirror image)
// Signals
//   pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load, a_load, b_load,
//   alu_en    : one-clock bus strobes
//   out_valid : out_data valid, held until out_ready
//   out_data  : captured A register value
//   out_ready : display accepts out_data
//   stall     : out_valid && !out_ready; control FSM holds its cycle
// -----------------------------------------------------------------------------
interface cpu_state_decode_if;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_load;
  logic       ram_rd;
  logic       ram_wr;
  logic       ir_load;
  logic       a_load;
  logic       b_load;
  logic       alu_en;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       stall;

  modport master (
    output pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load, a_load, b_load,
    output alu_en, out_valid, out_data, stall,
    input  out_ready
  );

  modport slave (
    input  pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load, a_load, b_load,
    input  alu_en, out_valid, out_data, stall,
    output out_ready
  );
endinterface

// File: rtl/cpu_state_decode.sv
// -----------------------------------------------------------------------------
// cpu_state_decode
//   Turns the control FSM's STATE_* code into registered one-clock bus strobes,
//   resolves conditional jumps, runs the OUT handshake with the display,
//   latches HALT and flags undefined state codes.
//
// Optional feature macro: CPU_DECODE_PERF_EN
//   defined   : retired_cnt / stall_cnt performance counters (CNT_W wide)
//   undefined : counters and their ports are absent, CNT_W is unused
//
// Ports
//   clk          clock, all outputs registered on posedge
//   reset_cycle  asynchronous active-high reset
//   state[3:0]   current STATE_* code
//   opcode[7:0]  current instruction byte (used by JUMP)
//   zero_flag    ALU zero flag, sampled together with state
//   reg_a[7:0]   A register value captured by OUT_A
//   bus          cpu_state_decode_if.master (strobes + OUT handshake)
//   halted       sticky halt
//   instr_done   one-clock pulse per retired instruction (NEXT)
//   illegal      sticky: undefined state code seen
//   retired_cnt, stall_cnt [CNT_W-1:0]  (CPU_DECODE_PERF_EN only)
// -----------------------------------------------------------------------------
module cpu_state_decode #(
  parameter int         CNT_W  = 16,
  parameter logic [7:0] OP_JMP = 8'h30,
  parameter logic [7:0] OP_JEZ = 8'h31,
  parameter logic [7:0] OP_JNZ = 8'h32
) (
  input  logic                  clk,
  input  logic                  reset_cycle,
  input  logic [3:0]            state,
  input  logic [7:0]            opcode,
  input  logic                  zero_flag,
  input  logic [7:0]            reg_a,
  cpu_state_decode_if.master    bus,
  output logic                  halted,
  output logic                  instr_done,
  output logic                  illegal
`ifdef CPU_DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  localparam logic [3:0] ST_FETCH_PC   = 4'd0;
  localparam logic [3:0] ST_FETCH_INST = 4'd1;
  localparam logic [3:0] ST_HALT       = 4'd2;
  localparam logic [3:0] ST_JUMP       = 4'd3;
  localparam logic [3:0] ST_OUT_A      = 4'd4;
  localparam logic [3:0] ST_NEXT       = 4'd5;
  localparam logic [3:0] ST_LDI        = 4'd6;
  localparam logic [3:0] ST_LOAD_ADDR  = 4'd7;
  localparam logic [3:0] ST_RAM_B      = 4'd8;
  localparam logic [3:0] ST_ALU_OP     = 4'd9;
  localparam logic [3:0] ST_MOV_FETCH  = 4'd10;
  localparam logic [3:0] ST_MOV_LOAD   = 4'd11;
  localparam logic [3:0] ST_MOV_STORE  = 4'd12;

  // Bit positions inside the strobe register
  localparam int I_PC_INC   = 0;
  localparam int I_PC_LOAD  = 1;
  localparam int I_MAR_LOAD = 2;
  localparam int I_RAM_RD   = 3;
  localparam int I_RAM_WR   = 4;
  localparam int I_IR_LOAD  = 5;
  localparam int I_A_LOAD   = 6;
  localparam int I_B_LOAD   = 7;
  localparam int I_ALU_EN   = 8;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  out_state_t out_state_reg, out_state_next;
  logic [7:0] out_data_reg,   out_data_next;
  logic [8:0] strobe_reg,     strobe_next;
  logic       instr_done_reg, instr_done_next;
  logic       halted_reg,     halted_next;
  logic       illegal_reg,    illegal_next;
  logic       stall_now;
  logic       decode_en;

  // While the display is holding us off, the control FSM re-presents the
  // same state; decoding it again would double-count pc_inc etc.
  assign stall_now = (out_state_reg == OUT_VALID) && !bus.out_ready;
  assign decode_en = !halted_reg && !stall_now;

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    strobe_next     = '0;
    instr_done_next = 1'b0;
    if (decode_en) begin
      case (state)
        ST_FETCH_PC: begin
          strobe_next[I_MAR_LOAD] = 1'b1;
        end
        ST_FETCH_INST: begin
          strobe_next[I_RAM_RD]  = 1'b1;
          strobe_next[I_IR_LOAD] = 1'b1;
          strobe_next[I_PC_INC]  = 1'b1;
        end
        ST_JUMP: begin
          // Not-taken conditional jumps step over the operand byte.
          // Any other opcode in JUMP produces no strobe.
          if (opcode == OP_JMP) begin
            strobe_next[I_PC_LOAD] = 1'b1;
          end else if (opcode == OP_JEZ) begin
            strobe_next[I_PC_LOAD] = zero_flag;
            strobe_next[I_PC_INC]  = !zero_flag;
          end else if (opcode == OP_JNZ) begin
            strobe_next[I_PC_LOAD] = !zero_flag;
            strobe_next[I_PC_INC]  = zero_flag;
          end
        end
        ST_NEXT: begin
          instr_done_next = 1'b1;
        end
        ST_LDI: begin
          strobe_next[I_RAM_RD] = 1'b1;
          strobe_next[I_A_LOAD] = 1'b1;
          strobe_next[I_PC_INC] = 1'b1;
        end
        ST_LOAD_ADDR, ST_MOV_FETCH: begin
          strobe_next[I_RAM_RD]   = 1'b1;
          strobe_next[I_MAR_LOAD] = 1'b1;
          strobe_next[I_PC_INC]   = 1'b1;
        end
        ST_RAM_B: begin
          strobe_next[I_RAM_RD] = 1'b1;
          strobe_next[I_B_LOAD] = 1'b1;
        end
        ST_ALU_OP: begin
          strobe_next[I_ALU_EN] = 1'b1;
          strobe_next[I_A_LOAD] = 1'b1;
        end
        ST_MOV_LOAD: begin
          strobe_next[I_RAM_RD] = 1'b1;
        end
        ST_MOV_STORE: begin
          strobe_next[I_RAM_WR] = 1'b1;
        end
        default: begin
          // HALT, OUT_A and undefined codes drive no bus strobe
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // OUT handshake FSM (next state / data)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_state_next = out_state_reg;
    out_data_next  = out_data_reg;
    case (out_state_reg)
      OUT_IDLE: begin
        if (decode_en && (state == ST_OUT_A)) begin
          out_state_next = OUT_VALID;
          out_data_next  = reg_a;
        end
      end
      OUT_VALID: begin
        // A repeated OUT_A here is ignored: no recapture of reg_a.
        if (bus.out_ready) begin
          out_state_next = OUT_IDLE;
        end
      end
      default: begin
        out_state_next = OUT_IDLE;
      end
    endcase
  end

  assign halted_next  = halted_reg | (decode_en && (state == ST_HALT));
  assign illegal_next = illegal_reg | (state > ST_MOV_STORE);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      out_state_reg  <= OUT_IDLE;
      out_data_reg   <= '0;
      strobe_reg     <= '0;
      instr_done_reg <= 1'b0;
      halted_reg     <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      out_state_reg  <= out_state_next;
      out_data_reg   <= out_data_next;
      strobe_reg     <= strobe_next;
      instr_done_reg <= instr_done_next;
      halted_reg     <= halted_next;
      illegal_reg    <= illegal_next;
    end
  end

`ifdef CPU_DECODE_PERF_EN
  logic [CNT_W-1:0] retired_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // Counted on the same edge that raises instr_done / during each stall clk.
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      retired_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      retired_cnt_reg <= retired_cnt_reg + {{(CNT_W-1){1'b0}}, instr_done_next};
      stall_cnt_reg   <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, stall_now};
    end
  end

  assign retired_cnt = retired_cnt_reg;
  assign stall_cnt   = stall_cnt_reg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc_inc    = strobe_reg[I_PC_INC];
  assign bus.pc_load   = strobe_reg[I_PC_LOAD];
  assign bus.mar_load  = strobe_reg[I_MAR_LOAD];
  assign bus.ram_rd    = strobe_reg[I_RAM_RD];
  assign bus.ram_wr    = strobe_reg[I_RAM_WR];
  assign bus.ir_load   = strobe_reg[I_IR_LOAD];
  assign bus.a_load    = strobe_reg[I_A_LOAD];
  assign bus.b_load    = strobe_reg[I_B_LOAD];
  assign bus.alu_en    = strobe_reg[I_ALU_EN];
  assign bus.out_valid = (out_state_reg == OUT_VALID);
  assign bus.out_data  = out_data_reg;
  assign bus.stall     = stall_now;
  assign halted        = halted_reg;
  assign instr_done    = instr_done_reg;
  assign illegal       = illegal_reg;

endmodule
